// File: rtl/ram_rr_arbiter_if.sv
// Requester and RAM-port bundle for ram_rr_arbiter.
// slave is the arbiter side; master is the requesters plus the RAM.
interface ram_rr_arbiter_if #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WIDTH_G   = 32,
    parameter int unsigned ADDRWIDTH = 6
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ-1:0]           req_we;
    logic [NUM_REQ-1:0]           req_lock;
    logic [NUM_REQ*ADDRWIDTH-1:0] req_addr;
    logic [NUM_REQ*WIDTH_G-1:0]   req_wdata;
    logic [NUM_REQ-1:0]           rsp_valid;
    logic [WIDTH_G-1:0]           rsp_data;
    logic                         ram_en;
    logic                         ram_we;
    logic [ADDRWIDTH-1:0]         ram_addr;
    logic [WIDTH_G-1:0]           ram_di;
    logic [WIDTH_G-1:0]           ram_do;

    modport slave (
        input  req_valid, req_we, req_lock, req_addr, req_wdata, ram_do,
        output req_ready, rsp_valid, rsp_data, ram_en, ram_we, ram_addr, ram_di
    );

    modport master (
        output req_valid, req_we, req_lock, req_addr, req_wdata, ram_do,
        input  req_ready, rsp_valid, rsp_data, ram_en, ram_we, ram_addr, ram_di
    );
endinterface

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing one block-RAM port among NUM_REQ requesters,
// with burst locking capped at MAX_BURST grants and in-order read return.
module ram_rr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WIDTH_G   = 32,
    parameter int unsigned ADDRWIDTH = 6,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned IDW       = 2
) (
    input logic              clk,
    input logic              rst_n,
    ram_rr_arbiter_if.slave  bus
);
    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] owner;
    logic [IDW-1:0] rspId;
    logic [IDW-1:0] grantIdx;
    logic [IDW-1:0] nextIdx;
    logic           ownerVld;
    logic           rspPend;
    logic           grantVld;
    logic           lockHeld;
    logic           lockCont;
    logic [BW-1:0]  burstCnt;
    logic [BW-1:0]  curCnt;

    // A lock only counts while its owner keeps requesting; otherwise the count restarts.
    assign lockHeld = ownerVld && bus.req_valid[owner];
    assign curCnt   = lockHeld ? burstCnt : '0;
    assign lockCont = bus.req_lock[grantIdx] && (32'(curCnt) + 32'd1 < MAX_BURST);
    assign nextIdx  = (32'(grantIdx) + 32'd1 >= NUM_REQ) ? '0 : grantIdx + 1'b1;

    always_comb begin
        int unsigned idx;
        idx      = 0;
        grantVld = 1'b0;
        grantIdx = '0;
        if (lockHeld) begin
            grantVld = 1'b1;
            grantIdx = owner;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                idx = 32'(ptr) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!grantVld && bus.req_valid[idx]) begin
                    grantVld = 1'b1;
                    grantIdx = IDW'(idx);
                end
            end
        end
    end

    // Gated by rst_n so nothing is issued while reset is held.
    assign bus.ram_en    = grantVld && rst_n;
    assign bus.req_ready = bus.ram_en ? (NUM_REQ'(1) << grantIdx) : '0;
    assign bus.ram_we    = bus.ram_en && bus.req_we[grantIdx];
    assign bus.ram_addr  = bus.req_addr[32'(grantIdx)*ADDRWIDTH +: ADDRWIDTH];
    assign bus.ram_di    = bus.req_wdata[32'(grantIdx)*WIDTH_G +: WIDTH_G];
    assign bus.rsp_valid = (rspPend && rst_n) ? (NUM_REQ'(1) << rspId) : '0;
    assign bus.rsp_data  = bus.ram_do;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            owner    <= '0;
            ownerVld <= 1'b0;
            burstCnt <= '0;
            rspPend  <= 1'b0;
            rspId    <= '0;
        end else begin
            rspPend <= grantVld && !bus.req_we[grantIdx];
            rspId   <= grantIdx;
            if (grantVld && lockCont) begin
                owner    <= grantIdx;
                ownerVld <= 1'b1;
                burstCnt <= curCnt + 1'b1;
            end else begin
                ownerVld <= 1'b0;
                burstCnt <= '0;
                if (grantVld) ptr <= nextIdx;
            end
        end
    end
endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed bench for ram_rr_arbiter: a 4-requester and a 3-requester instance,
// each backed by a registered read-first RAM model.
module tb_ram_rr_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ram_rr_arbiter_if #(.NUM_REQ(4), .WIDTH_G(32), .ADDRWIDTH(6)) i4 ();
    ram_rr_arbiter_if #(.NUM_REQ(3), .WIDTH_G(32), .ADDRWIDTH(6)) i3 ();

    ram_rr_arbiter #(
        .NUM_REQ(4), .WIDTH_G(32), .ADDRWIDTH(6), .MAX_BURST(8), .IDW(2)
    ) u4 (
        .clk(clk), .rst_n(rst_n), .bus(i4)
    );

    ram_rr_arbiter #(
        .NUM_REQ(3), .WIDTH_G(32), .ADDRWIDTH(6), .MAX_BURST(8), .IDW(2)
    ) u3 (
        .clk(clk), .rst_n(rst_n), .bus(i3)
    );

    logic [31:0] mem4 [64];
    logic [31:0] mem3 [64];

    initial begin
        for (int a = 0; a < 64; a++) begin
            mem4[a] = 32'hA500_0000 | 32'(a);
            mem3[a] = 32'hC300_0000 | 32'(a);
        end
    end

    always @(posedge clk) begin
        if (i4.ram_en) begin
            if (i4.ram_we) mem4[i4.ram_addr] <= i4.ram_di;
            i4.ram_do <= mem4[i4.ram_addr];
        end
        if (i3.ram_en) begin
            if (i3.ram_we) mem3[i3.ram_addr] <= i3.ram_di;
            i3.ram_do <= mem3[i3.ram_addr];
        end
    end

    // Inputs change 1 time unit after the rising edge; outputs are sampled 3 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        i4.req_valid = '0; i4.req_we = '0; i4.req_lock = '0;
        i4.req_addr  = '0; i4.req_wdata = '0;
        i3.req_valid = '0; i3.req_we = '0; i3.req_lock = '0;
        i3.req_addr  = '0; i3.req_wdata = '0;
    endtask

    task automatic set4(input int i, input logic v, input logic we, input logic lk,
                        input logic [5:0] a, input logic [31:0] d);
        i4.req_valid[i]        = v;
        i4.req_we[i]           = we;
        i4.req_lock[i]         = lk;
        i4.req_addr[i*6 +: 6]  = a;
        i4.req_wdata[i*32 +: 32] = d;
    endtask

    task automatic set3(input int i, input logic v, input logic we,
                        input logic [5:0] a, input logic [31:0] d);
        i3.req_valid[i]          = v;
        i3.req_we[i]             = we;
        i3.req_lock[i]           = 1'b0;
        i3.req_addr[i*6 +: 6]    = a;
        i3.req_wdata[i*32 +: 32] = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_all();
        i4.req_valid = 4'hF;
        i3.req_valid = 3'h7;
        #3;
        checks++;
        if (i4.req_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_ready4 got %b want %b", i4.req_ready, 4'b0000);
        end
        checks++;
        if (i4.ram_en !== 1'b0) begin
            errors++; $display("FAIL reset_ram_en got %b want 0", i4.ram_en);
        end
        checks++;
        if (i3.req_ready !== 3'b000) begin
            errors++; $display("FAIL reset_ready3 got %b want %b", i3.req_ready, 3'b000);
        end
        clear_all();
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            #3;
            checks++;
            if (i4.req_ready !== 4'b0000 || i4.ram_en !== 1'b0 || i4.rsp_valid !== 4'b0000) begin
                errors++;
                $display("FAIL idle cyc %0d got ready=%b en=%b rsp=%b want 0000/0/0000",
                         k, i4.req_ready, i4.ram_en, i4.rsp_valid);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp;
        logic [31:0] expData;
        for (int k = 0; k <= 8; k++) begin
            tick();
            if (k == 0) for (int i = 0; i < 4; i++) set4(i, 1'b1, 1'b0, 1'b0, 6'(10 + i), '0);
            if (k == 8) clear_all();
            #3;
            if (k < 8) begin
                exp = 4'b0001 << (k % 4);
                checks++;
                if (i4.req_ready !== exp || i4.ram_addr !== 6'(10 + k % 4) || i4.ram_we !== 1'b0) begin
                    errors++;
                    $display("FAIL rr_grant cyc %0d got ready=%b addr=%0d we=%b want %b/%0d/0",
                             k, i4.req_ready, i4.ram_addr, i4.ram_we, exp, 10 + k % 4);
                end
            end
            if (k > 0) begin
                exp     = 4'b0001 << ((k - 1) % 4);
                expData = 32'hA500_0000 | 32'(10 + (k - 1) % 4);
                checks++;
                if (i4.rsp_valid !== exp || i4.rsp_data !== expData) begin
                    errors++;
                    $display("FAIL rr_rsp cyc %0d got %b/%h want %b/%h",
                             k, i4.rsp_valid, i4.rsp_data, exp, expData);
                end
            end
        end
    endtask

    task automatic test_write_read();
        tick();
        set4(1, 1'b1, 1'b1, 1'b0, 6'd5, 32'hDEAD_BEEF);
        #3;
        checks++;
        if (i4.req_ready !== 4'b0010 || i4.ram_we !== 1'b1 || i4.ram_addr !== 6'd5 ||
            i4.ram_di !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wr_issue got ready=%b we=%b addr=%0d di=%h want 0010/1/5/deadbeef",
                     i4.req_ready, i4.ram_we, i4.ram_addr, i4.ram_di);
        end
        tick();
        set4(1, 1'b1, 1'b0, 1'b0, 6'd5, '0);
        #3;
        checks++;
        if (i4.req_ready !== 4'b0010 || i4.ram_we !== 1'b0 || i4.rsp_valid !== 4'b0000) begin
            errors++;
            $display("FAIL rd_issue got ready=%b we=%b rsp=%b want 0010/0/0000",
                     i4.req_ready, i4.ram_we, i4.rsp_valid);
        end
        tick();
        clear_all();
        #3;
        checks++;
        if (i4.rsp_valid !== 4'b0010 || i4.rsp_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wr_rd_rsp got %b/%h want 0010/deadbeef", i4.rsp_valid, i4.rsp_data);
        end
    endtask

    // ptr is 2 here: req2 locks for 8 grants, yields to req0, then re-locks.
    task automatic test_burst_lock();
        int          seq [12] = '{2, 2, 2, 2, 2, 2, 2, 2, 0, 2, 2, 2};
        logic [3:0]  exp;
        logic [31:0] expData;
        for (int k = 0; k <= 12; k++) begin
            tick();
            if (k == 0) begin
                set4(0, 1'b1, 1'b0, 1'b0, 6'd21, '0);
                set4(2, 1'b1, 1'b0, 1'b1, 6'd20, '0);
            end
            if (k == 12) clear_all();
            #3;
            if (k < 12) begin
                exp = 4'b0001 << seq[k];
                checks++;
                if (i4.req_ready !== exp) begin
                    errors++;
                    $display("FAIL burst_grant cyc %0d got %b want %b", k, i4.req_ready, exp);
                end
            end
            if (k > 0) begin
                exp     = 4'b0001 << seq[k-1];
                expData = 32'hA500_0000 | ((seq[k-1] == 2) ? 32'd20 : 32'd21);
                checks++;
                if (i4.rsp_valid !== exp || i4.rsp_data !== expData) begin
                    errors++;
                    $display("FAIL burst_rsp cyc %0d got %b/%h want %b/%h",
                             k, i4.rsp_valid, i4.rsp_data, exp, expData);
                end
            end
        end
    endtask

    // ptr is 1: req3 locks, drops valid in cycle 2, then must get a fresh 8-grant burst.
    task automatic test_lock_release();
        int          seq [12] = '{3, 3, 1, 3, 3, 3, 3, 3, 3, 3, 3, 1};
        logic [3:0]  exp;
        for (int k = 0; k <= 12; k++) begin
            tick();
            if (k == 12) begin
                clear_all();
            end else begin
                set4(3, (k != 2), 1'b0, 1'b1, 6'd33, '0);
                set4(1, (k >= 1), 1'b0, 1'b0, 6'd30, '0);
            end
            #3;
            if (k < 12) begin
                exp = 4'b0001 << seq[k];
                checks++;
                if (i4.req_ready !== exp) begin
                    errors++;
                    $display("FAIL release_grant cyc %0d got %b want %b", k, i4.req_ready, exp);
                end
            end
            if (k > 0) begin
                exp = 4'b0001 << seq[k-1];
                checks++;
                if (i4.rsp_valid !== exp) begin
                    errors++;
                    $display("FAIL release_rsp cyc %0d got %b want %b", k, i4.rsp_valid, exp);
                end
            end
            if (k == 3) begin
                checks++;
                if (u4.burstCnt !== 4'd0) begin
                    errors++;
                    $display("FAIL release_cnt got %0d want 0", u4.burstCnt);
                end
            end
        end
    endtask

    // Three requesters: req1 moves ptr to 2, then req2/req0 alternate with wrap 2 -> 0.
    task automatic test_three();
        logic        v0  [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
        logic        we0 [8] = '{0, 0, 0, 1, 1, 0, 0, 0};
        logic        v2  [8] = '{0, 1, 1, 1, 1, 1, 0, 0};
        logic        we2 [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
        logic [5:0]  a2  [8] = '{0, 7, 7, 7, 3, 3, 0, 0};
        logic [2:0]  rdy [8] = '{3'b010, 3'b100, 3'b001, 3'b100, 3'b001, 3'b100, 3'b001, 3'b000};
        logic        wen [8] = '{0, 1, 0, 0, 1, 0, 0, 0};
        logic [2:0]  rsp [8] = '{3'b000, 3'b010, 3'b000, 3'b001, 3'b100, 3'b000, 3'b100, 3'b001};
        logic [31:0] dat [8] = '{32'h0, 32'hC300_0001, 32'h0, 32'hC300_0003,
                                 32'h1111_1111, 32'h0, 32'h2222_2222, 32'h2222_2222};
        for (int k = 0; k < 8; k++) begin
            tick();
            set3(0, v0[k], we0[k], 6'd3, 32'h2222_2222);
            set3(1, (k == 0), 1'b0, 6'd1, '0);
            set3(2, v2[k], we2[k], a2[k], 32'h1111_1111);
            #3;
            checks++;
            if (i3.req_ready !== rdy[k] || (rdy[k] != 3'b000 && i3.ram_we !== wen[k])) begin
                errors++;
                $display("FAIL three_grant cyc %0d got %b/we=%b want %b/we=%b",
                         k, i3.req_ready, i3.ram_we, rdy[k], wen[k]);
            end
            checks++;
            if (i3.rsp_valid !== rsp[k] || (rsp[k] != 3'b000 && i3.rsp_data !== dat[k])) begin
                errors++;
                $display("FAIL three_rsp cyc %0d got %b/%h want %b/%h",
                         k, i3.rsp_valid, i3.rsp_data, rsp[k], dat[k]);
            end
        end
        tick();
        clear_all();
    endtask

    task automatic test_reset_mid_read();
        tick();
        set4(0, 1'b1, 1'b0, 1'b0, 6'd2, '0);
        #3;
        checks++;
        if (i4.req_ready !== 4'b0001) begin
            errors++; $display("FAIL midrst_issue got %b want 0001", i4.req_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        clear_all();
        #2;
        checks++;
        if (i4.rsp_valid !== 4'b0000 || i4.ram_en !== 1'b0) begin
            errors++;
            $display("FAIL midrst_rsp got rsp=%b en=%b want 0000/0", i4.rsp_valid, i4.ram_en);
        end
        tick();
        rst_n = 1'b1;
        tick();
        #3;
        checks++;
        if (i4.rsp_valid !== 4'b0000) begin
            errors++; $display("FAIL midrst_after got %b want 0000", i4.rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_write_read();
        test_burst_lock();
        test_lock_release();
        test_three();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_rr_arbiter.md
Name: ram_rr_arbiter

Overview:
- Shares one port (A or B) of the on-chip true dual-port block RAM among NUM_REQ requesters, e.g. the FAST, Harris and BRIEF stages of the ORB pipeline.
- Arbitration is round-robin with optional burst locking and a starvation cap.
- Write and read requests are muxed onto the RAM port.
- Each RAM read result is routed back to the requester that issued it, one cycle after acceptance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH_G, 32, RAM data width.
- ADDRWIDTH, 6, RAM address width.
- MAX_BURST, 8, maximum consecutive locked grants to one requester before forced rotation (>=1).
- IDW, 2, requester index width, = ceil(log2(NUM_REQ)).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  request valid, one bit per requester.
- req_ready  out  NUM_REQ  request accepted this cycle; at most one bit set.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_lock  in  NUM_REQ  requester wants to keep the grant next cycle (burst).
- req_addr  in  NUM_REQ*ADDRWIDTH  flattened addresses; requester i at [i*ADDRWIDTH +: ADDRWIDTH].
- req_wdata  in  NUM_REQ*WIDTH_G  flattened write data, same packing.
- rsp_valid  out  NUM_REQ  one-hot read-data-valid.
- rsp_data  out  WIDTH_G  read data, shared by all requesters.
- ram_en  out  1  RAM port enable.
- ram_we  out  1  RAM port write enable.
- ram_addr  out  ADDRWIDTH  RAM port address.
- ram_di  out  WIDTH_G  RAM port write data.
- ram_do  in  WIDTH_G  RAM port registered read data (1-cycle latency, read-first).

Behaviour:
- State registers:
  - ptr (IDW): round-robin priority pointer.
  - owner (IDW) + owner_vld: current lock holder.
  - burst_cnt (ceil(log2(MAX_BURST+1))).
  - rsp_pend (1) + rsp_id (IDW): outstanding read return.
- Reset (async, rst_n=0): ptr=0, owner_vld=0, burst_cnt=0, rsp_pend=0.
  - Outputs while in reset: req_ready=0, rsp_valid=0, ram_en=0, ram_we=0.
  - ram_addr, ram_di and rsp_data are don't-care while in reset.
  - A read accepted in the cycle before reset asserts produces no response.
- Grant (combinational, same cycle):
  - If owner_vld and req_valid[owner] = 1, then g = owner.
  - Otherwise g is the first i with req_valid[i]=1, searching ptr, ptr+1, … mod NUM_REQ.
  - No valid request → no grant: req_ready=0, ram_en=0.
- Issue: when a grant exists, req_ready[g]=1, ram_en=1, ram_we=req_we[g], ram_addr=req_addr[g], ram_di=req_wdata[g].
  - A transfer occurs when req_valid[g] & req_ready[g]; there is no other stall source.
  - Requesters must hold valid, we, addr and wdata stable until ready.
- Pointer/lock update on each transfer to g:
  - Locked continuation, when req_lock[g]=1 and burst_cnt+1 < MAX_BURST: owner=g, owner_vld=1, burst_cnt++, ptr unchanged.
  - Otherwise: owner_vld=0, burst_cnt=0, ptr=(g+1) mod NUM_REQ.
  - If the owner drops req_valid, the lock is released that cycle: owner_vld=0, burst_cnt=0, and normal round-robin grant applies in that same cycle.
  - MAX_BURST=1 disables locking.
- Read return:
  - Transfer with we=0 in cycle t sets rsp_pend=1, rsp_id=g for cycle t+1.
  - In cycle t+1: rsp_valid = one-hot(rsp_id), rsp_data = ram_do.
  - Writes and idle cycles clear rsp_pend.
  - Back-to-back reads give back-to-back responses; there is no response backpressure.
- Ordering: responses return in issue order, exactly one per accepted read. A write followed by a read to the same address on the next cycle returns the new data.
- Index arithmetic: wrap-around is modulo NUM_REQ, including non-power-of-2 values (e.g. NUM_REQ=3, ptr=2 → next 0).
- Never assert req_ready to a requester whose req_valid=0.

Test Plan:
- Reset then idle: all req_valid=0 → req_ready=0, ram_en=0, rsp_valid=0 for 10 cycles. Assert rst_n=0 mid-read → rsp_valid=0 on the following cycle.
- Round-robin: all 4 requesters read continuously, lock=0 → grant order 0,1,2,3,0,…; each rsp_valid one-hot arrives 1 cycle after its grant with the correct RAM word.
- Write/read: req1 writes 0xDEADBEEF to addr 5, then reads addr 5 → rsp_valid=4'b0010, rsp_data=0xDEADBEEF two cycles after the write.
- Burst lock, MAX_BURST=8: req2 holds lock=1 and valid for 12 cycles while req0 is valid → req2 gets 8 consecutive grants, then req0, then req2 again.
- Lock release: req3 drops valid mid-burst with req1 pending → req1 is granted in the same cycle, and burst_cnt reads 0 afterwards.
- NUM_REQ=3 instance: requesters 0 and 2 are valid, ptr=2 → grants alternate 2,0,2,0; a mix of writes and reads keeps in-order, one-to-one responses.
